// File: rtl/mux_pkg.sv
// Shared modes, default data value and width helper for the scanning N-to-1 multiplexer.
// No logic here; widths are resolved at each use site.
package mux_pkg;

    typedef enum logic {
        MODO_MANUAL = 1'b0,
        MODO_AUTO   = 1'b1
    } modo_t;

    // Replicated to ANCHO bits wherever an idle output is needed.
    localparam logic DEFECTO = 1'b0;

    // One extra code beyond N so that 0 can mean "no channel" with 1-based indices.
    function automatic int ancho_sel(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multiplexor_barrido_n_a_1_if.sv
// Bundle of data, control and result signals of the scanning multiplexer.
// master drives data/control and observes results; slave is the multiplexer.
interface multiplexor_barrido_n_a_1_if
    import mux_pkg::*;
#(
    parameter int N_ENTRADAS = 4,
    parameter int ANCHO      = 3
) ();

    localparam int ANCHO_SEL = ancho_sel(N_ENTRADAS);

    logic [N_ENTRADAS*ANCHO-1:0] entradas;
    logic [ANCHO_SEL-1:0]        selector;
    logic                        modo;
    logic                        retener;
    logic [ANCHO-1:0]            salida;
    logic                        valida;
    logic [ANCHO_SEL-1:0]        canal;
    logic                        fin_barrido;

    modport master (
        output entradas, selector, modo, retener,
        input  salida, valida, canal, fin_barrido
    );

    modport slave (
        input  entradas, selector, modo, retener,
        output salida, valida, canal, fin_barrido
    );

endinterface

// File: rtl/contador_barrido.sv
// Scan index (1..N) with per-channel dwell counter and wrap flag; indice/envuelta reflect
// the state used this cycle, with a pending restart already applied. Holds when not enabled.
module contador_barrido #(
    parameter int N_ENTRADAS  = 4,
    parameter int PERMANENCIA = 2,
    parameter int ANCHO_SEL   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 habilitar,
    input  logic                 reiniciar,
    output logic [ANCHO_SEL-1:0] indice,
    output logic                 envuelta
);

    localparam int ANCHO_DW = (PERMANENCIA > 1) ? $clog2(PERMANENCIA) : 1;

    logic [ANCHO_SEL-1:0] indice_q;
    logic [ANCHO_DW-1:0]  dwell_q;
    logic                 envuelta_q;
    logic [ANCHO_SEL-1:0] indice_ef;
    logic [ANCHO_DW-1:0]  dwell_ef;

    // A restart takes effect in the same cycle: that cycle is the first dwell cycle of channel 1.
    always_comb begin
        indice_ef = reiniciar ? ANCHO_SEL'(1) : indice_q;
        dwell_ef  = reiniciar ? '0 : dwell_q;
        indice    = indice_ef;
        envuelta  = envuelta_q & ~reiniciar;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            indice_q   <= ANCHO_SEL'(1);
            dwell_q    <= '0;
            envuelta_q <= 1'b0;
        end else if (habilitar) begin
            if (dwell_ef == ANCHO_DW'(PERMANENCIA - 1)) begin
                dwell_q <= '0;
                if (indice_ef == ANCHO_SEL'(N_ENTRADAS)) begin
                    indice_q   <= ANCHO_SEL'(1);
                    envuelta_q <= 1'b1;
                end else begin
                    indice_q   <= indice_ef + 1'b1;
                    envuelta_q <= 1'b0;
                end
            end else begin
                dwell_q    <= dwell_ef + 1'b1;
                indice_q   <= indice_ef;
                envuelta_q <= 1'b0;
            end
        end else if (reiniciar) begin
            indice_q   <= ANCHO_SEL'(1);
            dwell_q    <= '0;
            envuelta_q <= 1'b0;
        end
    end

endmodule

// File: rtl/multiplexor_barrido_n_a_1.sv
// Registered N-to-1 mux: manual 1-based selection or automatic round-robin scan; 1-cycle latency.
// No backpressure; retener freezes outputs and scan state.
module multiplexor_barrido_n_a_1
    import mux_pkg::*;
#(
    parameter int N_ENTRADAS  = 4,
    parameter int ANCHO       = 3,
    parameter int PERMANENCIA = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    multiplexor_barrido_n_a_1_if.slave  bus
);

    localparam int ANCHO_SEL = ancho_sel(N_ENTRADAS);

    modo_t                modo_q;
    logic                 cambio;
    logic                 habilitar;
    logic                 reiniciar;
    logic [ANCHO_SEL-1:0] indice;
    logic                 envuelta;
    logic [ANCHO-1:0]     dato_manual;
    logic [ANCHO-1:0]     dato_auto;
    logic                 selector_ok;

    logic [ANCHO-1:0]     salida_q;
    logic                 valida_q;
    logic [ANCHO_SEL-1:0] canal_q;
    logic                 fin_q;

    // Mode changes are only acted on outside a hold, so a change during a hold is seen after release.
    always_comb begin
        cambio    = (modo_t'(bus.modo) != modo_q);
        reiniciar = cambio & ~bus.retener;
        habilitar = (modo_t'(bus.modo) == MODO_AUTO) & ~bus.retener;
    end

    contador_barrido #(
        .N_ENTRADAS  (N_ENTRADAS),
        .PERMANENCIA (PERMANENCIA),
        .ANCHO_SEL   (ANCHO_SEL)
    ) u_contador (
        .clk       (clk),
        .rst       (rst),
        .habilitar (habilitar),
        .reiniciar (reiniciar),
        .indice    (indice),
        .envuelta  (envuelta)
    );

    always_comb begin
        dato_manual = {ANCHO{DEFECTO}};
        dato_auto   = {ANCHO{DEFECTO}};
        selector_ok = 1'b0;
        for (int i = 0; i < N_ENTRADAS; i++) begin
            if (bus.selector == ANCHO_SEL'(i + 1)) begin
                dato_manual = bus.entradas[i*ANCHO +: ANCHO];
                selector_ok = 1'b1;
            end
            if (indice == ANCHO_SEL'(i + 1)) begin
                dato_auto = bus.entradas[i*ANCHO +: ANCHO];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            salida_q <= {ANCHO{DEFECTO}};
            valida_q <= 1'b0;
            canal_q  <= '0;
            fin_q    <= 1'b0;
            modo_q   <= MODO_MANUAL;
        end else if (bus.retener) begin
            fin_q    <= 1'b0;
        end else begin
            modo_q <= modo_t'(bus.modo);
            if (modo_t'(bus.modo) == MODO_AUTO) begin
                salida_q <= dato_auto;
                valida_q <= 1'b1;
                canal_q  <= indice;
                fin_q    <= envuelta;
            end else begin
                salida_q <= dato_manual;
                valida_q <= selector_ok;
                canal_q  <= selector_ok ? bus.selector : '0;
                fin_q    <= 1'b0;
            end
        end
    end

    assign bus.salida      = salida_q;
    assign bus.valida      = valida_q;
    assign bus.canal       = canal_q;
    assign bus.fin_barrido = fin_q;

endmodule

// File: tb/tb_multiplexor_barrido_n_a_1.sv
// Bench for multiplexor_barrido_n_a_1: directed scenarios then random traffic against a
// position-counting reference model.
module tb_multiplexor_barrido_n_a_1;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int P  = 2;

    logic clk = 1'b0;
    logic rst;

    multiplexor_barrido_n_a_1_if #(.N_ENTRADAS(N), .ANCHO(W)) bus ();

    multiplexor_barrido_n_a_1 #(
        .N_ENTRADAS  (N),
        .ANCHO       (W),
        .PERMANENCIA (P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Channel data, 1-based
    logic [W-1:0] d [1:N];

    // Reference model: scan position = number of non-held auto cycles since the last restart
    int       pos;
    logic     mprev;
    logic [W-1:0] e_sal;
    logic     e_val;
    int       e_can;
    logic     e_fin;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_tests++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
        end
    endtask

    task automatic cargar_datos();
        for (int k = 1; k <= N; k++) bus.entradas[(k-1)*W +: W] = d[k];
    endtask

    task automatic modelo();
        int sel;
        int ch;
        sel = int'(bus.selector);
        if (rst) begin
            pos = 0; mprev = 1'b0;
            e_sal = '0; e_val = 1'b0; e_can = 0; e_fin = 1'b0;
        end else if (bus.retener) begin
            e_fin = 1'b0;
        end else begin
            if (bus.modo != mprev) pos = 0;
            mprev = bus.modo;
            if (bus.modo) begin
                ch    = (pos / P) % N + 1;
                e_sal = d[ch];
                e_val = 1'b1;
                e_can = ch;
                e_fin = (pos != 0) && (pos % (N * P) == 0);
                pos++;
            end else begin
                e_fin = 1'b0;
                if (sel >= 1 && sel <= N) begin
                    e_sal = d[sel]; e_val = 1'b1; e_can = sel;
                end else begin
                    e_sal = '0; e_val = 1'b0; e_can = 0;
                end
            end
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs sampled 1 time unit later.
    task automatic ciclo();
        @(posedge clk);
        modelo();
        #1;
        comprobar("salida", 32'(bus.salida), 32'(e_sal));
        comprobar("valida", 32'(bus.valida), 32'(e_val));
        comprobar("canal",  32'(bus.canal),  32'(e_can));
        comprobar("fin",    32'(bus.fin_barrido), 32'(e_fin));
    endtask

    task automatic esperar_canal(input int objetivo);
        int n;
        n = 0;
        while (e_can != objetivo && n < 20) begin
            ciclo();
            n++;
        end
        comprobar("espera_canal", 32'(e_can), 32'(objetivo));
    endtask

    initial begin
        int seq [10] = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1};
        int msel [7] = '{0, 1, 2, 3, 4, 5, 7};
        int mexp [7] = '{0, 1, 2, 3, 4, 0, 0};

        for (int k = 1; k <= N; k++) d[k] = W'(k);
        cargar_datos();
        rst = 1'b1; bus.modo = 1'b0; bus.retener = 1'b0; bus.selector = '0;
        pos = 0; mprev = 1'b0; e_sal = '0; e_val = 1'b0; e_can = 0; e_fin = 1'b0;

        // Reset
        ciclo(); ciclo();
        comprobar("reset_salida", 32'(bus.salida), 0);
        comprobar("reset_canal",  32'(bus.canal), 0);
        rst = 1'b0;

        // Manual sweep
        for (int i = 0; i < 7; i++) begin
            bus.selector = 3'(msel[i]);
            ciclo();
            comprobar("manual_sweep", 32'(bus.salida), 32'(mexp[i]));
        end

        // Auto scan, with channel 3 data changed mid-dwell
        bus.modo = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ciclo();
            comprobar("canal_seq", 32'(bus.canal), 32'(seq[i]));
            comprobar("fin_seq", 32'(bus.fin_barrido), (i == 8) ? 1 : 0);
            if (i == 5) comprobar("dato_vivo", 32'(bus.salida), 6);
            if (i == 4) begin d[3] = 3'd6; cargar_datos(); end
        end
        d[3] = 3'd3; cargar_datos();

        // Hold at channel 2, then remaining dwell before channel 3
        ciclo();
        comprobar("hold_entrada", 32'(bus.canal), 2);
        bus.retener = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.selector = 3'($urandom_range(0, 7));
            ciclo();
            comprobar("hold_canal", 32'(bus.canal), 2);
        end
        bus.retener = 1'b0;
        ciclo();
        comprobar("hold_resto", 32'(bus.canal), 2);
        ciclo();
        comprobar("hold_sig", 32'(bus.canal), 3);

        // Mode toggle from canal 3
        esperar_canal(3);
        bus.modo = 1'b0; bus.selector = 3'd4;
        ciclo();
        comprobar("toggle_manual", 32'(bus.salida), 4);
        bus.modo = 1'b1;
        ciclo();
        comprobar("toggle_auto_canal", 32'(bus.canal), 1);
        comprobar("toggle_auto_fin", 32'(bus.fin_barrido), 0);

        // Reset mid-scan at canal 4
        esperar_canal(4);
        rst = 1'b1;
        ciclo();
        comprobar("rst_mid_valida", 32'(bus.valida), 0);
        rst = 1'b0;
        ciclo();
        comprobar("rst_restart", 32'(bus.canal), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            bus.retener = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 10) bus.modo = ~bus.modo;
            bus.selector = 3'($urandom_range(0, 7));
            for (int k = 1; k <= N; k++) d[k] = 3'($urandom_range(0, 7));
            cargar_datos();
            ciclo();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
